rvvi_stream: RTL and testbench
==============================

# rvvi_stream

Buffered, variable-length serializer for compressed RVVI trace records. Sits downstream of the synthesizable RVVI bridge: it accepts one full-width record per retired instruction, queues it in a DEPTH-entry FIFO, trims unused CSR slots, and streams the remainder as BEAT_W-bit beats over a valid/ready handshake toward a trace transport such as Ethernet or a debug FIFO. Overflow is either back-pressured into the pipeline or dropped and counted, selected at compile time.

## Interface
- XLEN, 64, register width; header, register and CSR fields scale with it.
- MAX_CSRS, 5, CSR slots per record.
- BEAT_W, 64, output beat width; any value ≥ 8.
- DEPTH, 4, record FIFO entries; power of two, ≥ 2.
- Derived: HDR_W = 56+3·XLEN, REG_W = 16+2·XLEN, CSR_W = XLEN+16, REC_W = HDR_W+REG_W+MAX_CSRS·CSR_W.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rec_valid  in  1  record offered this cycle.
- rec_ready  out  1  FIFO not full.
- rec  in  REC_W  packed record: header in low bits, then registers, then CSR slots. CSRCount is the 12-bit field at header bits [HDR_W-5 : HDR_W-16].
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_data  out  BEAT_W  beat payload, LSB-first within the record.
- out_last  out  1  final beat of the record.
- stall_req  out  1  back-pressure request to the pipeline.
- drop_count  out  16  saturating count of dropped records.
- overflow  out  1  sticky; set on the first drop.

## Operation
- **Enqueue:** the FIFO accepts a record when rec_valid & rec_ready.
  - Effective CSR count n = min(CSRCount, MAX_CSRS).
  - Record length L = HDR_W + REG_W + n·CSR_W. The register field is always sent.
  - Stored beat count B = ceil(L / BEAT_W), computed at enqueue and stored with the entry.
- **Drop:** rec_valid & ~rec_ready discards the record, increments drop_count (holds at 0xFFFF) and sets overflow. No partial record is ever emitted.
- **Serializer FSM:**
  - IDLE → SEND when the FIFO is non-empty; beat index idx = 0.
  - In SEND, out_valid = 1 and out_data = record bits [idx·BEAT_W +: BEAT_W]. Bits at or above L are forced to 0.
  - out_last = (idx == B-1).
  - On out_ready: if not last, idx++. If last, pop the FIFO, then go to IDLE if the FIFO is empty, otherwise start the next record with idx = 0 and no bubble cycle.
- **Handshake:** out_data and out_last must stay stable while out_valid & ~out_ready. out_valid never drops before its beat is accepted.
- **Simultaneous push and pop on a full FIFO:** rec_ready reflects occupancy before the pop, so the push is refused (dropped, or stalled under back-pressure).

## Timing
- Reset values: out_valid 0, out_last 0, out_data 0, rec_ready 1, stall_req 0, drop_count 0, overflow 0. FSM returns to IDLE and the FIFO empties.
- Reset is asynchronous. Asserting it mid-record aborts the record immediately; no further beats of it are sent.
- Latency: a record accepted at cycle N into an empty FIFO produces its first beat (out_valid = 1) at cycle N+1.
- Throughput: one beat per cycle while out_ready stays high, including across record boundaries.
- rec_ready is registered from occupancy and does not depend combinationally on out_ready.

## Configuration
- RVVI_BACKPRESSURE_EN defined: stall_req = 1 whenever occupancy ≥ DEPTH-1, driven from a register. The source is required to hold rec_valid low while stalled. Drops remain counted in case this contract is violated.
- RVVI_BACKPRESSURE_EN undefined: stall_req is tied 0. Overflowing records are dropped and counted.

## Structure
- Shared package rvvi_pkg holds:
  - functions for HDR_W, REG_W, CSR_W and REC_W of XLEN and MAX_CSRS;
  - the CSRCount field offsets;
  - the beat-count function ceil(L / BEAT_W).
- Sub-module rvvi_fifo: a parametrised synchronous FIFO (width REC_W plus beat count, DEPTH entries) with full, empty and occupancy outputs.
- The serializer FSM, beat mux/mask and drop counter live in rvvi_stream.

## Test plan
All scenarios use the default parameters: XLEN=64, MAX_CSRS=5, BEAT_W=64, DEPTH=4.
- One record with CSRCount=0, out_ready held at 1 → 7 beats (L=392). Beat 6 has bits [7:0] from the record and bits [63:8] all zero; out_last only on beat 6.
- CSRCount=5, then CSRCount=2, back to back → 13 beats then 9 beats, no idle cycle between them. out_last on the 13th and 22nd beats.
- CSRCount=9 → clamped to 5; 13 beats are sent and bits above 792 are absent.
- out_ready toggling 1,0,0,1 mid-record → out_data and out_last held stable through both stall cycles; beat order preserved.
- With out_ready=0, push 6 records without the macro → 4 queued, rec_ready=0 after the 4th, drop_count=2, overflow=1. With the macro → stall_req=1 once occupancy reaches 3.
- Assert reset during beat 3 of a 13-beat record → out_valid=0 immediately, FIFO empty. After release, a new record starts at beat 0 one cycle after acceptance.

Source files
------------

// File: rtl/rvvi_pkg.sv
// rvvi_pkg: record-layout widths, CSRCount field offsets, beat-count helper and
// serializer state type shared by the rvvi_stream slice.
package rvvi_pkg;

  localparam int unsigned CSR_CNT_W      = 12;
  // CSRCount occupies header bits [HDR_W-5 : HDR_W-16]
  localparam int unsigned CSR_CNT_HI_OFS = 5;
  localparam int unsigned CSR_CNT_LO_OFS = 16;

  typedef enum logic {IDLE, SEND} ser_state_t;

  function automatic int unsigned hdr_w(input int unsigned xlen);
    return 56 + 3 * xlen;
  endfunction

  function automatic int unsigned reg_w(input int unsigned xlen);
    return 16 + 2 * xlen;
  endfunction

  function automatic int unsigned csr_w(input int unsigned xlen);
    return xlen + 16;
  endfunction

  function automatic int unsigned rec_w(input int unsigned xlen, input int unsigned max_csrs);
    return hdr_w(xlen) + reg_w(xlen) + max_csrs * csr_w(xlen);
  endfunction

  function automatic int unsigned beat_count(input int unsigned len, input int unsigned beat_w);
    return (len + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/rvvi_stream_if.sv
// rvvi_stream_if: record-in and beat-out valid/ready channels of the trace serializer.
interface rvvi_stream_if
  import rvvi_pkg::*;
#(
  parameter int unsigned REC_W  = rec_w(64, 5),
  parameter int unsigned BEAT_W = 64
);
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec;
  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rec_valid, rec, out_ready,
    input  rec_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  rec_valid, rec, out_ready,
    output rec_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rvvi_fifo.sv
// rvvi_fifo: synchronous DEPTH-entry FIFO with registered full/empty flags and occupancy.
module rvvi_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count;
    if (do_push && !do_pop)      count_d = count + 1'b1;
    else if (!do_push && do_pop) count_d = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/rvvi_stream.sv
// rvvi_stream: trims unused CSR slots, queues records and streams them as BEAT_W beats.
// Define RVVI_BACKPRESSURE_EN to drive stall_req from FIFO occupancy; otherwise it is tied 0.
module rvvi_stream
  import rvvi_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MAX_CSRS = 5,
  parameter int unsigned BEAT_W   = 64,
  parameter int unsigned DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  rvvi_stream_if.slave      bus,
  output logic              stall_req,
  output logic [15:0]       drop_count,
  output logic              overflow
);
  localparam int unsigned HDR_W     = hdr_w(XLEN);
  localparam int unsigned REG_W     = reg_w(XLEN);
  localparam int unsigned CSR_W     = csr_w(XLEN);
  localparam int unsigned REC_W     = rec_w(XLEN, MAX_CSRS);
  localparam int unsigned MAX_BEATS = beat_count(REC_W, BEAT_W);
  localparam int unsigned BCNT_W    = $clog2(MAX_BEATS + 1);
  localparam int unsigned PAD_W     = MAX_BEATS * BEAT_W;
  localparam int unsigned ENT_W     = REC_W + BCNT_W;
  localparam int unsigned CW        = $clog2(DEPTH + 1);

  logic [CSR_CNT_W-1:0] csr_cnt;
  int unsigned          n_csr, rec_len;
  logic [REC_W-1:0]     rec_trim, head_rec;
  logic [BCNT_W-1:0]    beats_in, head_beats, idx_q, idx_d;
  logic [ENT_W-1:0]     head;
  logic [PAD_W-1:0]     padded;
  logic [CW-1:0]        count;
  logic                 push, pop, full, empty, last_beat, out_valid;
  ser_state_t           state_q, state_d;

  assign csr_cnt = bus.rec[HDR_W-CSR_CNT_HI_OFS -: CSR_CNT_W];

  // Unused CSR slots are zeroed at enqueue so the beat mux never needs a length mask.
  always_comb begin
    n_csr    = (32'(csr_cnt) > MAX_CSRS) ? MAX_CSRS : 32'(csr_cnt);
    rec_len  = HDR_W + REG_W + n_csr * CSR_W;
    beats_in = BCNT_W'(beat_count(rec_len, BEAT_W));
    rec_trim = bus.rec;
    for (int unsigned i = 0; i < MAX_CSRS; i++) begin
      if (i >= n_csr) rec_trim[HDR_W + REG_W + i*CSR_W +: CSR_W] = '0;
    end
  end

  assign push          = bus.rec_valid & ~full;
  assign bus.rec_ready = ~full;

  rvvi_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({beats_in, rec_trim}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_rec   = head[REC_W-1:0];
  assign head_beats = head[ENT_W-1 -: BCNT_W];
  assign padded     = PAD_W'(head_rec);
  assign last_beat  = (idx_q == head_beats - 1'b1);

  // IDLE presents beat 0 as soon as the FIFO is non-empty, giving one-cycle latency.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        out_valid = ~empty;
        if (!empty) state_d = SEND;
      end
      SEND: out_valid = 1'b1;
    endcase
    if (out_valid && bus.out_ready) begin
      if (last_beat) begin
        pop     = 1'b1;
        idx_d   = '0;
        state_d = (count == CW'(1) && !push) ? IDLE : SEND;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_valid & last_beat;

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < MAX_BEATS; k++) begin
      if (out_valid && idx_q == BCNT_W'(k)) bus.out_data = padded[k*BEAT_W +: BEAT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (bus.rec_valid && full) begin
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
      overflow <= 1'b1;
    end
  end

`ifdef RVVI_BACKPRESSURE_EN
  logic [CW-1:0] count_nx;
  logic          stall_q;

  assign count_nx = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= 1'b0;
    else        stall_q <= (count_nx >= CW'(DEPTH - 1));
  end

  assign stall_req = stall_q;
`else
  assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_rvvi_stream.sv
// tb_rvvi_stream: directed + random records checked against a bit-length reference model.
module tb_rvvi_stream;
  localparam int unsigned HDR_W = 248;
  localparam int unsigned REC_W = 792;
  localparam int unsigned PAD_W = 832;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        stall_req;
  logic [15:0] drop_count;
  logic        overflow;

  rvvi_stream_if #(.REC_W(REC_W), .BEAT_W(64)) bus ();

  rvvi_stream #(.XLEN(64), .MAX_CSRS(5), .BEAT_W(64), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stall_req  (stall_req),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  beat_t       exp_q [$];
  int unsigned occ, drops, beats_seen, lasts_seen;
  logic        mon_acc, mon_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [REC_W-1:0] make_rec(input int unsigned c);
    logic [799:0] t;
    t = '0;
    for (int i = 0; i < 25; i++) t = (t << 32) | 800'($urandom);
    t[HDR_W-5:HDR_W-16] = 12'(c);
    return t[REC_W-1:0];
  endfunction

  // Reference: keep the first L bits of the record, L from the clamped CSR count.
  task automatic add_record(input logic [REC_W-1:0] r);
    logic [PAD_W-1:0] bits;
    int unsigned c, n, len, nb;
    c    = 32'(r[HDR_W-5:HDR_W-16]);
    n    = (c > 5) ? 5 : c;
    len  = 248 + 144 + n * 80;
    nb   = (len + 63) / 64;
    bits = PAD_W'(r) & ~({PAD_W{1'b1}} << len);
    for (int unsigned k = 0; k < nb; k++)
      exp_q.push_back('{last: (k == nb - 1), data: 64'(bits >> (k * 64))});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      occ   = 0;
      drops = 0;
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_out_last", 64'(bus.out_last), 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_rec_ready", 64'(bus.rec_ready), 1);
      check("rst_stall", 64'(stall_req), 0);
      check("rst_drop_count", 64'(drop_count), 0);
      check("rst_overflow", 64'(overflow), 0);
    end else begin
      mon_acc = (occ < DEPTH);
`ifdef RVVI_BACKPRESSURE_EN
      mon_stall = (occ >= DEPTH - 1);
`else
      mon_stall = 1'b0;
`endif
      check("rec_ready", 64'(bus.rec_ready), 64'(mon_acc));
      check("stall_req", 64'(stall_req), 64'(mon_stall));
      check("drop_count", 64'(drop_count), 64'(drops));
      check("overflow", 64'(overflow), 64'(drops != 0));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_data", bus.out_data, exp_q[0].data);
        check("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
        if (bus.out_ready) begin
          beats_seen++;
          if (exp_q[0].last) begin
            lasts_seen++;
            occ--;
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus.rec_valid) begin
        if (mon_acc) begin
          add_record(bus.rec);
          occ++;
        end else if (drops != 32'hFFFF) begin
          drops++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned c);
    bus.rec       = make_rec(c);
    bus.rec_valid = 1'b1;
    step();
    bus.rec_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size() != 0), 0);
  endtask

  initial begin
    int unsigned b0, l0;
    reset         = 1'b0;
    bus.rec_valid = 1'b0;
    bus.rec       = '0;
    bus.out_ready = 1'b0;
    beats_seen    = 0;
    lasts_seen    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("init_rec_ready", 64'(bus.rec_ready), 1);
    check("init_out_valid", 64'(bus.out_valid), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    step();

    // CSRCount=0: 7 beats, one latency cycle
    bus.out_ready = 1'b1;
    b0 = beats_seen; l0 = lasts_seen;
    push(0);
    check("t1_latency", 64'(bus.out_valid), 1);
    drain("t1_drain");
    check("t1_beats", 64'(beats_seen - b0), 7);
    check("t1_lasts", 64'(lasts_seen - l0), 1);

    // CSRCount=5 then 2 back to back: 13 + 9 beats
    b0 = beats_seen; l0 = lasts_seen;
    push(5);
    push(2);
    drain("t2_drain");
    check("t2_beats", 64'(beats_seen - b0), 22);
    check("t2_lasts", 64'(lasts_seen - l0), 2);

    // CSRCount=9 clamps to 5
    b0 = beats_seen;
    push(9);
    drain("t3_drain");
    check("t3_beats", 64'(beats_seen - b0), 13);

    // out_ready 1,0,0,1 mid-record
    push(5);
    step();
    bus.out_ready = 1'b0;
    step();
    step();
    bus.out_ready = 1'b1;
    drain("t4_drain");

    // overflow with sink stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push($urandom_range(0, 15));
`ifdef RVVI_BACKPRESSURE_EN
      if (i == 2) check("t5_stall_at3", 64'(stall_req), 1);
`else
      if (i == 2) check("t5_stall_tied", 64'(stall_req), 0);
`endif
      if (i == 3) check("t5_ready_at4", 64'(bus.rec_ready), 0);
    end
    check("t5_rec_ready", 64'(bus.rec_ready), 0);
    check("t5_drop_count", 64'(drop_count), 2);
    check("t5_overflow", 64'(overflow), 1);
    b0 = lasts_seen;
    bus.out_ready = 1'b1;
    drain("t5_drain");
    check("t5_records", 64'(lasts_seen - b0), 4);

    // random traffic
    repeat (300) begin
      bus.rec_valid = ($urandom_range(0, 2) == 0);
      bus.rec       = make_rec($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.rec_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("t6_drain");

    // reset during beat 3 of a 13-beat record
    push(5);
    step();
    step();
    step();
    #1 reset = 1'b0;
    #1;
    check("t7_abort_valid", 64'(bus.out_valid), 0);
    check("t7_abort_ready", 64'(bus.rec_ready), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    step();
    check("t7_idle_after", 64'(bus.out_valid), 0);
    b0 = beats_seen;
    push(1);
    check("t7_latency", 64'(bus.out_valid), 1);
    drain("t7_drain");
    check("t7_beats", 64'(beats_seen - b0), 8);
    check("t7_drop_cleared", 64'(drop_count), 0);
    check("t7_ovf_cleared", 64'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
